blackjack_state_ram: RTL and testbench
======================================

# blackjack_state_ram

Parametrised game-state store for the blackjack datapath. It holds balance, bet, card count and card slots for NUM_PLAYERS player hands plus one dealer hand. The game FSM drives it through a command port with a valid/ready handshake. Balance, bet and card updates are atomic read-modify-write operations with error reporting, and NEW_ROUND is a multi-cycle sweep that clears the table. A second read-only port serves the display logic.

## Interface
- CURRENCY_BITS, 16: width of every stored word.
- MAX_CARDS, 7: card slots per hand.
- NUM_PLAYERS, 2: player hands; the dealer hand index is NUM_PLAYERS.
- START_BALANCE, 1000: balance loaded into every hand on reset.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  3  0 READ, 1 WRITE, 2 BAL_ADD, 3 BAL_SUB, 4 PLACE_BET, 5 PUSH_CARD, 6 CLEAR_HAND, 7 NEW_ROUND.
- cmd_hand  in  clog2(NUM_PLAYERS+1)  hand select.
- cmd_word  in  clog2(3+MAX_CARDS)  word within the hand: 0 balance, 1 bet, 2 count, 3+k card k.
- cmd_data  in  CURRENCY_BITS  operand.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  CURRENCY_BITS  result.
- rsp_err  out  1  command rejected; qualified by rsp_valid.
- disp_hand, disp_word  in  as cmd_hand/cmd_word  display read address.
- disp_data  out  CURRENCY_BITS  registered display read.

## Operation
- Storage: (NUM_PLAYERS+1) × (3+MAX_CARDS) words in a register array.
- Reset: every balance = START_BALANCE and every other word = 0. Reset also forces rsp_valid=0, rsp_data=0, rsp_err=0, disp_data=0 and state IDLE.
- FSM states: IDLE, EXEC, SWEEP.
  - IDLE: capture the command on accept, then go to EXEC, or to SWEEP for NEW_ROUND.
  - EXEC: read the operands, compute, write back, assert the response, return to IDLE.
  - SWEEP: a hand counter runs 0..NUM_PLAYERS. Each cycle it sets bet=0 and count=0 for that hand. After the last hand it responds and returns to IDLE.
- READ: rsp_data = word.
- WRITE: word = cmd_data; rsp_data = cmd_data.
- BAL_ADD: balance += cmd_data, saturating at all-ones with no error; rsp_data = new balance.
- BAL_SUB: if cmd_data > balance, then err and the balance is unchanged; otherwise balance -= cmd_data. rsp_data = resulting balance.
- PLACE_BET: if bet != 0 or cmd_data > balance, then err. Otherwise balance -= cmd_data and bet = cmd_data in the same write. rsp_data = resulting bet.
- PUSH_CARD: if count == MAX_CARDS, then err. Otherwise card[count] = cmd_data[3:0] zero-extended, and count += 1. rsp_data = resulting count.
- CLEAR_HAND: count = 0 and bet = 0; rsp_data = 0. Card slots keep stale values.
- NEW_ROUND: applies CLEAR_HAND to all hands; rsp_data = 0; the balances and card slots are untouched.
- cmd_hand > NUM_PLAYERS, or cmd_word ≥ 3+MAX_CARDS (checked for READ/WRITE): err, no state change, rsp_data = 0.
- On any err, no word is modified.
- Display port: disp_data <= word(disp_hand, disp_word) on every edge. An out-of-range display address returns 0.

## Timing
- All commands except NEW_ROUND: accepted at edge N, writeback at edge N+1. rsp_valid is high for the cycle after edge N+1, and cmd_ready is low for that cycle.
- cmd_ready returns high after the edge N+2. Throughput is one command per 3 cycles at most.
- NEW_ROUND: accepted at edge N, sweep writes at edges N+1..N+NUM_PLAYERS+1. rsp_valid is high for the cycle after the last sweep write.
- cmd_valid is ignored while cmd_ready is low; no queueing.
- The display read takes 1 cycle. If it hits a word being written on the same edge, it returns the pre-write value; the new value is visible on the following read.
- Reset asserted mid-command: the command is aborted, no response is issued and memory is reinitialised. On deassertion the block is in IDLE with cmd_ready=1.

## Test plan
- After reset: READ hand0 word0 returns 1000; READ hand1 word1 returns 0 with err=0; rsp_valid arrives exactly 2 edges after accept.
- BAL_SUB 1001 on balance 1000 gives err=1 and rsp_data=1000. PLACE_BET 100 then gives balance 900, rsp_data=100. A second PLACE_BET 50 gives err=1.
- PUSH_CARD 7 times on hand2 (dealer) with values 1..7 gives counts 1..7; an 8th push gives err=1 and rsp_data=7. Display reads of card words return 1..7.
- BAL_ADD 0xFFFF on balance 900 gives rsp_data 0xFFFF with err=0.
- NEW_ROUND with NUM_PLAYERS=2: cmd_ready stays low for 4 cycles after accept; afterwards all bets and counts are 0 and the balances are unchanged.
- Assert rst during the SWEEP: no rsp_valid; after release, READ hand0 word0 returns 1000.

Source files
------------

// File: rtl/blackjack_state_ram.sv
// Game-state store for the blackjack datapath: per-hand balance, bet, card count and card slots.
// Commands run as atomic read-modify-write operations; a separate registered port serves the display.
module blackjack_state_ram #(
    parameter int unsigned CURRENCY_BITS = 16,
    parameter int unsigned MAX_CARDS     = 7,
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned START_BALANCE = 1000,
    localparam int unsigned NUM_HANDS    = NUM_PLAYERS + 1,
    localparam int unsigned NUM_WORDS    = 3 + MAX_CARDS,
    localparam int unsigned HAND_BITS    = $clog2(NUM_HANDS),
    localparam int unsigned WORD_BITS    = $clog2(NUM_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [HAND_BITS-1:0]     cmd_hand,
    input  logic [WORD_BITS-1:0]     cmd_word,
    input  logic [CURRENCY_BITS-1:0] cmd_data,
    output logic                     rsp_valid,
    output logic [CURRENCY_BITS-1:0] rsp_data,
    output logic                     rsp_err,
    input  logic [HAND_BITS-1:0]     disp_hand,
    input  logic [WORD_BITS-1:0]     disp_word,
    output logic [CURRENCY_BITS-1:0] disp_data
);

    localparam logic [2:0] OpRead      = 3'd0;
    localparam logic [2:0] OpWrite     = 3'd1;
    localparam logic [2:0] OpBalAdd    = 3'd2;
    localparam logic [2:0] OpBalSub    = 3'd3;
    localparam logic [2:0] OpPlaceBet  = 3'd4;
    localparam logic [2:0] OpPushCard  = 3'd5;
    localparam logic [2:0] OpClearHand = 3'd6;
    localparam logic [2:0] OpNewRound  = 3'd7;

    localparam logic [WORD_BITS-1:0] WordBal = WORD_BITS'(0);
    localparam logic [WORD_BITS-1:0] WordBet = WORD_BITS'(1);
    localparam logic [WORD_BITS-1:0] WordCnt = WORD_BITS'(2);

    typedef enum logic [1:0] {StIdle, StExec, StSweep} state_e;

    state_e                   r_state, w_state_next;
    logic [2:0]               r_op;
    logic [HAND_BITS-1:0]     r_hand;
    logic [WORD_BITS-1:0]     r_word;
    logic [CURRENCY_BITS-1:0] r_data;
    logic [HAND_BITS-1:0]     r_sweep;
    logic                     r_rsp_valid;
    logic [CURRENCY_BITS-1:0] r_rsp_data;
    logic                     r_rsp_err;
    logic [CURRENCY_BITS-1:0] r_disp_data;
    logic [CURRENCY_BITS-1:0] r_mem [NUM_HANDS][NUM_WORDS];

    logic                     w_hand_ok, w_word_ok, w_disp_ok, w_sweep_last, w_accept;
    logic [HAND_BITS-1:0]     w_hsel, w_disp_hsel;
    logic [WORD_BITS-1:0]     w_wsel, w_disp_wsel;
    logic [CURRENCY_BITS-1:0] w_bal, w_bet, w_cnt, w_word_val;
    logic [CURRENCY_BITS:0]   w_bal_sum;
    logic                     w_wa_en, w_wb_en;
    logic [WORD_BITS-1:0]     w_wa_word, w_wb_word;
    logic [CURRENCY_BITS-1:0] w_wa_data, w_wb_data;
    logic [CURRENCY_BITS-1:0] w_rsp_data;
    logic                     w_rsp_err;

    // Ready drops during the response cycle so throughput is one command per three cycles.
    assign cmd_ready    = (r_state == StIdle) && !r_rsp_valid;
    assign w_accept     = cmd_valid && cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign disp_data    = r_disp_data;

    assign w_hand_ok    = 32'(r_hand) <= NUM_PLAYERS;
    assign w_word_ok    = 32'(r_word) < NUM_WORDS;
    assign w_hsel       = w_hand_ok ? r_hand : '0;
    assign w_wsel       = w_word_ok ? r_word : '0;
    assign w_bal        = r_mem[w_hsel][WordBal];
    assign w_bet        = r_mem[w_hsel][WordBet];
    assign w_cnt        = r_mem[w_hsel][WordCnt];
    assign w_word_val   = r_mem[w_hsel][w_wsel];
    assign w_bal_sum    = {1'b0, w_bal} + {1'b0, r_data};
    assign w_sweep_last = r_sweep == HAND_BITS'(NUM_PLAYERS);

    assign w_disp_ok    = (32'(disp_hand) <= NUM_PLAYERS) && (32'(disp_word) < NUM_WORDS);
    assign w_disp_hsel  = w_disp_ok ? disp_hand : '0;
    assign w_disp_wsel  = w_disp_ok ? disp_word : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = (cmd_op == OpNewRound) ? StSweep : StExec;
            StExec:  w_state_next = StIdle;
            StSweep: if (w_sweep_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Each operation writes at most two words of the selected hand (port a, port b).
    always_comb begin
        w_wa_en    = 1'b0;
        w_wa_word  = '0;
        w_wa_data  = '0;
        w_wb_en    = 1'b0;
        w_wb_word  = '0;
        w_wb_data  = '0;
        w_rsp_data = '0;
        w_rsp_err  = 1'b0;
        if (!w_hand_ok) begin
            w_rsp_err = 1'b1;
        end else begin
            case (r_op)
                OpRead: begin
                    if (w_word_ok) w_rsp_data = w_word_val;
                    else           w_rsp_err  = 1'b1;
                end
                OpWrite: begin
                    if (w_word_ok) begin
                        w_wa_en    = 1'b1;
                        w_wa_word  = r_word;
                        w_wa_data  = r_data;
                        w_rsp_data = r_data;
                    end else begin
                        w_rsp_err = 1'b1;
                    end
                end
                OpBalAdd: begin
                    w_wa_en    = 1'b1;
                    w_wa_word  = WordBal;
                    w_wa_data  = w_bal_sum[CURRENCY_BITS] ? '1 : w_bal_sum[CURRENCY_BITS-1:0];
                    w_rsp_data = w_wa_data;
                end
                OpBalSub: begin
                    if (r_data > w_bal) begin
                        w_rsp_err  = 1'b1;
                        w_rsp_data = w_bal;
                    end else begin
                        w_wa_en    = 1'b1;
                        w_wa_word  = WordBal;
                        w_wa_data  = w_bal - r_data;
                        w_rsp_data = w_wa_data;
                    end
                end
                OpPlaceBet: begin
                    if ((w_bet != '0) || (r_data > w_bal)) begin
                        w_rsp_err  = 1'b1;
                        w_rsp_data = w_bet;
                    end else begin
                        w_wa_en    = 1'b1;
                        w_wa_word  = WordBal;
                        w_wa_data  = w_bal - r_data;
                        w_wb_en    = 1'b1;
                        w_wb_word  = WordBet;
                        w_wb_data  = r_data;
                        w_rsp_data = r_data;
                    end
                end
                OpPushCard: begin
                    if (w_cnt >= CURRENCY_BITS'(MAX_CARDS)) begin
                        w_rsp_err  = 1'b1;
                        w_rsp_data = w_cnt;
                    end else begin
                        w_wa_en    = 1'b1;
                        w_wa_word  = WORD_BITS'(32'd3 + 32'(w_cnt));
                        w_wa_data  = {{(CURRENCY_BITS-4){1'b0}}, r_data[3:0]};
                        w_wb_en    = 1'b1;
                        w_wb_word  = WordCnt;
                        w_wb_data  = w_cnt + CURRENCY_BITS'(1);
                        w_rsp_data = w_wb_data;
                    end
                end
                OpClearHand: begin
                    w_wa_en   = 1'b1;
                    w_wa_word = WordBet;
                    w_wb_en   = 1'b1;
                    w_wb_word = WordCnt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_op        <= '0;
            r_hand      <= '0;
            r_word      <= '0;
            r_data      <= '0;
            r_sweep     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_disp_data <= '0;
            for (int h = 0; h < NUM_HANDS; h++) begin
                for (int w = 0; w < NUM_WORDS; w++) begin
                    r_mem[h][w] <= (w == 0) ? CURRENCY_BITS'(START_BALANCE) : '0;
                end
            end
        end else begin
            r_state     <= w_state_next;
            r_rsp_valid <= 1'b0;
            r_disp_data <= w_disp_ok ? r_mem[w_disp_hsel][w_disp_wsel] : '0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_hand  <= cmd_hand;
                        r_word  <= cmd_word;
                        r_data  <= cmd_data;
                        r_sweep <= '0;
                    end
                end
                StExec: begin
                    if (w_wa_en) r_mem[w_hsel][w_wa_word] <= w_wa_data;
                    if (w_wb_en) r_mem[w_hsel][w_wb_word] <= w_wb_data;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_rsp_data;
                    r_rsp_err   <= w_rsp_err;
                end
                StSweep: begin
                    r_mem[r_sweep][WordBet] <= '0;
                    r_mem[r_sweep][WordCnt] <= '0;
                    r_sweep                 <= r_sweep + HAND_BITS'(1);
                    if (w_sweep_last) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blackjack_state_ram.sv
// Self-checking bench for blackjack_state_ram: responses are scored against a queue of expected
// {data, err} pairs pushed when each command is driven; timing and display checks are inline.
module tb_blackjack_state_ram;

    localparam logic [2:0] OP_READ = 3'd0, OP_WRITE = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
    localparam logic [2:0] OP_BET = 3'd4, OP_PUSH = 3'd5, OP_CLEAR = 3'd6, OP_NEW = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_hand;
    logic [3:0]  cmd_word;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  disp_hand;
    logic [3:0]  disp_word;
    logic [15:0] disp_data;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;

    blackjack_state_ram #(
        .CURRENCY_BITS(16),
        .MAX_CARDS    (7),
        .NUM_PLAYERS  (2),
        .START_BALANCE(1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_hand (cmd_hand),
        .cmd_word (cmd_word),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .disp_hand(disp_hand),
        .disp_word(disp_word),
        .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    // Scoreboard: every response pulse is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL rsp_unexpected: got data=%h err=%b, required no response",
                         rsp_data, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_data, rsp_err} !== {mon_e.d, mon_e.e}) begin
                    n_fails++;
                    $display("FAIL rsp_scoreboard: got data=%h err=%b, required data=%h err=%b",
                             rsp_data, rsp_err, mon_e.d, mon_e.e);
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] ed, input logic ee);
        exp_t e;
        e.d = ed;
        e.e = ee;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] hand, input logic [3:0] word,
                         input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_hand  = hand;
        cmd_word  = word;
        cmd_data  = data;
    endtask

    // Issue one command and wait until the block is ready again; the scoreboard checks the result.
    task automatic do_cmd(input logic [2:0] op, input logic [1:0] hand, input logic [3:0] word,
                          input logic [15:0] data, input logic [15:0] ed, input logic ee);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (t >= 20) begin
            n_fails++;
            $display("FAIL ready_timeout_pre: got cmd_ready=%b, required 1 within 20 cycles",
                     cmd_ready);
        end
        push_exp(ed, ee);
        drive(op, hand, word, data);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (cmd_ready !== 1'b1 && t < 20);
        n_checks++;
        if (t >= 20) begin
            n_fails++;
            $display("FAIL ready_timeout_post: got cmd_ready=%b, required 1 within 20 cycles",
                     cmd_ready);
        end
    endtask

    task automatic test_reset();
        disp_hand = 2'd0;
        disp_word = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (disp_data !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_disp: got %h, required 0000", disp_data);
        end
        rst = 1'b1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_fails++;
            $display("FAIL reset_outputs: got ready=%b valid=%b err=%b data=%h, required 1 0 0 0000",
                     cmd_ready, rsp_valid, rsp_err, rsp_data);
        end
        @(posedge clk); #1;
        n_checks++;
        if (disp_data !== 16'd1000) begin
            n_fails++;
            $display("FAIL reset_disp_balance: got %0d, required 1000", disp_data);
        end
        push_exp(16'd1000, 1'b0);
        drive(OP_READ, 2'd0, 4'd0, 16'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b00) begin
            n_fails++;
            $display("FAIL timing_exec: got valid=%b ready=%b, required 0 0", rsp_valid, cmd_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b10) begin
            n_fails++;
            $display("FAIL timing_rsp: got valid=%b ready=%b, required 1 0", rsp_valid, cmd_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL timing_ready: got valid=%b ready=%b, required 0 1", rsp_valid, cmd_ready);
        end
        do_cmd(OP_READ, 2'd1, 4'd1, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic test_range_errors();
        do_cmd(OP_READ,  2'd3, 4'd0,  16'd0,    16'd0, 1'b1);
        do_cmd(OP_READ,  2'd0, 4'd10, 16'd0,    16'd0, 1'b1);
        do_cmd(OP_WRITE, 2'd0, 4'd15, 16'd5,    16'd0, 1'b1);
        do_cmd(OP_ADD,   2'd3, 4'd0,  16'd5,    16'd0, 1'b1);
        do_cmd(OP_READ,  2'd0, 4'd0,  16'd0,    16'd1000, 1'b0);
    endtask

    task automatic test_balance_bet();
        do_cmd(OP_SUB, 2'd0, 4'd0, 16'd1001,  16'd1000,  1'b1);
        do_cmd(OP_BET, 2'd0, 4'd0, 16'd100,   16'd100,   1'b0);
        do_cmd(OP_READ, 2'd0, 4'd0, 16'd0,    16'd900,   1'b0);
        do_cmd(OP_BET, 2'd0, 4'd0, 16'd50,    16'd100,   1'b1);
        do_cmd(OP_READ, 2'd0, 4'd0, 16'd0,    16'd900,   1'b0);
        do_cmd(OP_ADD, 2'd0, 4'd0, 16'hFFFF,  16'hFFFF,  1'b0);
        do_cmd(OP_SUB, 2'd0, 4'd0, 16'h0FFF,  16'hF000,  1'b0);
        do_cmd(OP_BET, 2'd1, 4'd0, 16'd1001,  16'd0,     1'b1);
        do_cmd(OP_READ, 2'd1, 4'd0, 16'd0,    16'd1000,  1'b0);
    endtask

    task automatic test_cards();
        for (int k = 0; k < 7; k++) begin
            do_cmd(OP_PUSH, 2'd2, 4'd0, 16'hFFF0 | 16'(k + 1), 16'(k + 1), 1'b0);
        end
        do_cmd(OP_PUSH, 2'd2, 4'd0, 16'd8, 16'd7, 1'b1);
        disp_hand = 2'd2;
        for (int k = 0; k < 7; k++) begin
            disp_word = 4'(3 + k);
            @(posedge clk); #1;
            n_checks++;
            if (disp_data !== 16'(k + 1)) begin
                n_fails++;
                $display("FAIL disp_card%0d: got %h, required %h", k, disp_data, 16'(k + 1));
            end
        end
        disp_hand = 2'd3;
        disp_word = 4'd0;
        @(posedge clk); #1;
        n_checks++;
        if (disp_data !== 16'd0) begin
            n_fails++;
            $display("FAIL disp_bad_hand: got %h, required 0000", disp_data);
        end
        disp_hand = 2'd0;
        disp_word = 4'd12;
        @(posedge clk); #1;
        n_checks++;
        if (disp_data !== 16'd0) begin
            n_fails++;
            $display("FAIL disp_bad_word: got %h, required 0000", disp_data);
        end
    endtask

    task automatic test_write_collision();
        do_cmd(OP_WRITE, 2'd1, 4'd5, 16'h1234, 16'h1234, 1'b0);
        do_cmd(OP_READ,  2'd1, 4'd5, 16'd0,    16'h1234, 1'b0);
        disp_hand = 2'd1;
        disp_word = 4'd5;
        push_exp(16'hABCD, 1'b0);
        drive(OP_WRITE, 2'd1, 4'd5, 16'hABCD);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (disp_data !== 16'h1234) begin
            n_fails++;
            $display("FAIL disp_prewrite: got %h, required 1234", disp_data);
        end
        @(posedge clk); #1;
        n_checks++;
        if (disp_data !== 16'hABCD) begin
            n_fails++;
            $display("FAIL disp_postwrite: got %h, required abcd", disp_data);
        end
    endtask

    task automatic test_clear_hand();
        do_cmd(OP_CLEAR, 2'd0, 4'd0, 16'd0, 16'd0,    1'b0);
        do_cmd(OP_READ,  2'd0, 4'd1, 16'd0, 16'd0,    1'b0);
        do_cmd(OP_READ,  2'd0, 4'd0, 16'd0, 16'hF000, 1'b0);
    endtask

    task automatic test_new_round();
        do_cmd(OP_BET, 2'd1, 4'd0, 16'd200, 16'd200, 1'b0);
        push_exp(16'd0, 1'b0);
        drive(OP_NEW, 2'd0, 4'd0, 16'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({cmd_ready, rsp_valid} !== {1'b0, (i == 3)}) begin
                n_fails++;
                $display("FAIL sweep_cycle%0d: got ready=%b valid=%b, required 0 %b",
                         i, cmd_ready, rsp_valid, (i == 3));
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL sweep_ready: got %b, required 1", cmd_ready);
        end
        do_cmd(OP_READ, 2'd1, 4'd1, 16'd0, 16'd0,    1'b0);
        do_cmd(OP_READ, 2'd1, 4'd0, 16'd0, 16'd800,  1'b0);
        do_cmd(OP_READ, 2'd2, 4'd2, 16'd0, 16'd0,    1'b0);
        do_cmd(OP_READ, 2'd2, 4'd3, 16'd0, 16'd1,    1'b0);
        do_cmd(OP_READ, 2'd0, 4'd0, 16'd0, 16'hF000, 1'b0);
        do_cmd(OP_PUSH, 2'd2, 4'd0, 16'd9, 16'd1,    1'b0);
        do_cmd(OP_READ, 2'd2, 4'd3, 16'd0, 16'd9,    1'b0);
    endtask

    task automatic test_reset_in_sweep();
        do_cmd(OP_BET, 2'd0, 4'd0, 16'd10, 16'd10, 1'b0);
        drive(OP_NEW, 2'd0, 4'd0, 16'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fails++;
                $display("FAIL abort_no_rsp%0d: got valid=%b, required 0", i, rsp_valid);
            end
            @(posedge clk); #1;
        end
        do_cmd(OP_READ, 2'd0, 4'd0, 16'd0, 16'd1000, 1'b0);
        do_cmd(OP_READ, 2'd0, 4'd1, 16'd0, 16'd0,    1'b0);
        do_cmd(OP_READ, 2'd2, 4'd3, 16'd0, 16'd0,    1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_hand  = 2'd0;
        cmd_word  = 4'd0;
        cmd_data  = 16'd0;
        disp_hand = 2'd0;
        disp_word = 4'd0;
        #1;
        test_reset();
        test_range_errors();
        test_balance_bet();
        test_cards();
        test_write_collision();
        test_clear_hand();
        test_new_round();
        test_reset_in_sweep();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
